// File: rtl/sram_port_arbiter.sv
// Round-robin share of one SRAM port between two Avalon-MM masters with bounded lock; grant is same-cycle (waitrequest low = accepted).
// Read data valid exactly 1 cycle after a read accept; the SRAM_ARB_STATS_EN build adds saturating grant/conflict counters.
module sram_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] sram_address,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  input  logic [DATA_W-1:0] sram_readdata
`ifdef SRAM_ARB_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_conflict
`endif
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {UNLOCKED, LOCK0, LOCK1} lock_state_t;

  lock_state_t       state, state_nxt;
  logic              last, last_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              req0, req1;
  logic              grant0, grant1;
  logic              acc0, acc1;
  logic              hold_ok;
  logic              rdv0, rdv1;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign acc0    = grant0 & req0;
  assign acc1    = grant1 & req1;
  assign hold_ok = hold_cnt < HOLD_W'(MAX_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= UNLOCKED;
      last     <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Any cycle without a locked accept releases the lock: covers owner idle, unlock and forced hand-over.
  // Owner accepts only count toward MAX_HOLD while the other master is waiting.
  always_comb begin
    state_nxt = UNLOCKED;
    hold_nxt  = '0;
    last_nxt  = last;
    if (acc0) begin
      last_nxt = 1'b0;
      if (m0_lock) begin
        state_nxt = LOCK0;
        hold_nxt  = ((state == LOCK0) ? hold_cnt : '0) + HOLD_W'(req1);
      end
    end else if (acc1) begin
      last_nxt = 1'b1;
      if (m1_lock) begin
        state_nxt = LOCK1;
        hold_nxt  = ((state == LOCK1) ? hold_cnt : '0) + HOLD_W'(req0);
      end
    end
  end

  // An exhausted owner has last == owner, so the round-robin branch hands the port to the waiter.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end else if (state == LOCK0 && req0 && hold_ok) begin
      grant0 = 1'b1;
    end else if (state == LOCK1 && req1 && hold_ok) begin
      grant1 = 1'b1;
    end else if (req0 && req1) begin
      grant0 = last;
      grant1 = ~last;
    end else begin
      grant0 = req0;
      grant1 = req1;
    end
  end

  assign m0_waitrequest = ~grant0;
  assign m1_waitrequest = ~grant1;

  always_comb begin
    sram_address    = '0;
    sram_byteenable = '0;
    sram_chipselect = 1'b0;
    sram_write      = 1'b0;
    sram_writedata  = '0;
    if (grant0) begin
      sram_address    = m0_address;
      sram_byteenable = m0_write ? m0_byteenable : '1;
      sram_chipselect = 1'b1;
      sram_write      = m0_write;
      sram_writedata  = m0_writedata;
    end else if (grant1) begin
      sram_address    = m1_address;
      sram_byteenable = m1_write ? m1_byteenable : '1;
      sram_chipselect = 1'b1;
      sram_write      = m1_write;
      sram_writedata  = m1_writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdv0 <= 1'b0;
      rdv1 <= 1'b0;
    end else begin
      rdv0 <= acc0 & ~m0_write;
      rdv1 <= acc1 & ~m1_write;
    end
  end

  // Gated so a read accepted just before reset never reports data during reset.
  assign m0_readdatavalid = rdv0 & ~reset;
  assign m1_readdatavalid = rdv1 & ~reset;
  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_grant0   <= '0;
      stat_grant1   <= '0;
      stat_conflict <= '0;
    end else begin
      if (acc0 && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
      if (acc1 && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
      if (req0 && req1 && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-master request drivers, a behavioural SRAM, and a scoreboard
// of expected accept order and read data checked by an independent monitor.
module tb_sram_port_arbiter;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        lock;
    logic [7:0]  addr;
    logic [3:0]  be;
    logic [31:0] d;
  } cmd_t;

  logic        clk, reset;
  logic [7:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [7:0]  sram_address;
  logic [3:0]  sram_byteenable;
  logic        sram_chipselect, sram_write;
  logic [31:0] sram_writedata, sram_readdata;
`ifdef SRAM_ARB_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  cmd_t        q0[$], q1[$];
  int          exp_acc[$];
  logic [31:0] exp_rd0[$], exp_rd1[$];
  bit          busy0, busy1;
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] mem [0:255];

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable), .sram_chipselect(sram_chipselect),
    .sram_write(sram_write), .sram_writedata(sram_writedata), .sram_readdata(sram_readdata)
`ifdef SRAM_ARB_STATS_EN
    , .stat_clear(stat_clear), .stat_grant0(stat_grant0), .stat_grant1(stat_grant1),
    .stat_conflict(stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM behaviour: read-old-data, q valid the cycle after the address is clocked.
  always @(posedge clk) begin
    if (sram_chipselect) begin
      for (int i = 0; i < 4; i++)
        if (sram_write && sram_byteenable[i]) mem[sram_address][8*i +: 8] <= sram_writedata[8*i +: 8];
      sram_readdata <= mem[sram_address];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input bit rd, input bit wr, input bit lk, input logic [7:0] a,
                              input logic [3:0] be, input logic [31:0] d);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.lock = lk; c.addr = a; c.be = be; c.d = d;
    return c;
  endfunction

  task automatic push(input int n, input cmd_t c);
    if (n == 0) q0.push_back(c);
    else        q1.push_back(c);
  endtask

  task automatic set_sig(input int n, input cmd_t c);
    if (n == 0) begin
      m0_read = c.rd; m0_write = c.wr; m0_lock = c.lock;
      m0_address = c.addr; m0_byteenable = c.be; m0_writedata = c.d;
    end else begin
      m1_read = c.rd; m1_write = c.wr; m1_lock = c.lock;
      m1_address = c.addr; m1_byteenable = c.be; m1_writedata = c.d;
    end
  endtask

  function automatic logic wq(input int n);
    return (n == 0) ? m0_waitrequest : m1_waitrequest;
  endfunction

  // Holds each command stable until accepted; an all-zero command idles the master for one cycle.
  task automatic driver(input int n);
    cmd_t c;
    int   k;
    set_sig(n, '0);
    forever begin
      @(posedge clk); #1;
      if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
        set_sig(n, '0);
        if (n == 0) busy0 = 1'b0; else busy1 = 1'b0;
      end else begin
        if (n == 0) begin c = q0.pop_front(); busy0 = 1'b1; end
        else        begin c = q1.pop_front(); busy1 = 1'b1; end
        set_sig(n, c);
        if (c.rd || c.wr) begin
          k = 0;
          @(negedge clk);
          while (wq(n) && k < 200) begin @(negedge clk); k++; end
          if (k >= 200) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL accept_timeout master %0d: still waiting after %0d cycles", n, k);
          end
        end
      end
    end
  endtask

  initial driver(0);
  initial driver(1);

  initial begin : monitor
    bit prev_rd0, prev_rd1, a0, a1;
    prev_rd0 = 1'b0;
    prev_rd1 = 1'b0;
    forever begin
      @(negedge clk);
      check("rdv0_timing", 32'(m0_readdatavalid), 32'(prev_rd0 && !reset));
      check("rdv1_timing", 32'(m1_readdatavalid), 32'(prev_rd1 && !reset));
      if (m0_readdatavalid) begin
        if (exp_rd0.size() == 0) check("rd0_unexpected", 32'(exp_rd0.size()), 32'd1);
        else check("rd0_data", m0_readdata, exp_rd0.pop_front());
      end
      if (m1_readdatavalid) begin
        if (exp_rd1.size() == 0) check("rd1_unexpected", 32'(exp_rd1.size()), 32'd1);
        else check("rd1_data", m1_readdata, exp_rd1.pop_front());
      end
      a0 = (m0_read || m0_write) && !m0_waitrequest;
      a1 = (m1_read || m1_write) && !m1_waitrequest;
      if (a0) begin
        if (exp_acc.size() == 0) check("acc0_unexpected", 32'(exp_acc.size()), 32'd1);
        else check("accept_order", 32'd0, exp_acc.pop_front());
      end
      if (a1) begin
        if (exp_acc.size() == 0) check("acc1_unexpected", 32'(exp_acc.size()), 32'd1);
        else check("accept_order", 32'd1, exp_acc.pop_front());
      end
      prev_rd0 = a0 && m0_read && !m0_write;
      prev_rd1 = a1 && m1_read && !m1_write;
      if (reset) begin
        check("reset_wait0", 32'(m0_waitrequest), 32'd1);
        check("reset_wait1", 32'(m1_waitrequest), 32'd1);
        check("reset_cs", 32'(sram_chipselect), 32'd0);
      end
      if (sram_chipselect && !sram_write) check("read_be", 32'(sram_byteenable), 32'hF);
    end
  end

  task automatic run_phase(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1) && k < 500);
    if (k >= 500) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL %s: phase not drained after %0d cycles", name, k);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : main
    int k;
    reset = 1'b1;
`ifdef SRAM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // write then read back on m0 only
    @(negedge clk);
    push(0, mk(1'b0, 1'b1, 1'b0, 8'h12, 4'hF, 32'hDEADBEEF));
    push(0, mk(1'b1, 1'b0, 1'b0, 8'h12, 4'h0, 32'h0));
    exp_acc.push_back(0); exp_acc.push_back(0);
    exp_rd0.push_back(32'hDEADBEEF);
    run_phase("t1_write_read");

    // contended preload: m0 was last, so m1 wins first
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push(0, mk(1'b0, 1'b1, 1'b0, 8'h20 + 8'(i), 4'hF, 32'hA5000020 + 32'(i)));
      push(1, mk(1'b0, 1'b1, 1'b0, 8'h30 + 8'(i), 4'hF, 32'hA5000030 + 32'(i)));
      exp_acc.push_back(1); exp_acc.push_back(0);
    end
    run_phase("preload");

    // after reset m0 wins first contention; reads alternate
    pulse_reset(2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push(0, mk(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i), 4'h0, 32'h0));
      push(1, mk(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i), 4'h0, 32'h0));
      exp_acc.push_back(0); exp_acc.push_back(1);
      exp_rd0.push_back(32'hA5000020 + 32'(i));
      exp_rd1.push_back(32'hA5000030 + 32'(i));
    end
    run_phase("t2_rr_reads");

    // locked burst: m0 x4, forced hand-over to m1, m0 x2 with a fresh count, then m1
    @(negedge clk);
    for (int i = 0; i < 6; i++)
      push(0, mk(1'b0, 1'b1, 1'b1, 8'h40 + 8'(i), 4'hF, 32'hC0DE0000 + 32'(i)));
    push(1, mk(1'b0, 1'b1, 1'b0, 8'h50, 4'hF, 32'hB0000050));
    push(1, mk(1'b0, 1'b1, 1'b0, 8'h51, 4'hF, 32'hB0000051));
    exp_acc.push_back(0); exp_acc.push_back(0); exp_acc.push_back(0); exp_acc.push_back(0);
    exp_acc.push_back(1); exp_acc.push_back(0); exp_acc.push_back(0); exp_acc.push_back(1);
    run_phase("t3_lock");
    @(negedge clk);
    push(0, mk(1'b1, 1'b0, 1'b0, 8'h45, 4'h0, 32'h0));
    push(1, mk(1'b1, 1'b0, 1'b0, 8'h51, 4'h0, 32'h0));
    exp_acc.push_back(0); exp_acc.push_back(1);
    exp_rd0.push_back(32'hC0DE0005);
    exp_rd1.push_back(32'hB0000051);
    run_phase("t3_readback");

    // byte-lane merge, with an idle cycle before the read-back
    @(negedge clk);
    push(0, mk(1'b0, 1'b1, 1'b0, 8'h05, 4'hF, 32'hFFFFFFFF));
    push(0, mk(1'b0, 1'b1, 1'b0, 8'h05, 4'h3, 32'h0000AAAA));
    push(0, '0);
    push(0, mk(1'b1, 1'b0, 1'b0, 8'h05, 4'h0, 32'h0));
    exp_acc.push_back(0); exp_acc.push_back(0); exp_acc.push_back(0);
    exp_rd0.push_back(32'hFFFFAAAA);
    run_phase("t4_byteenable");

    // reset the cycle after an m1 read accept: no valid for m1; m0 request stalls through reset
    @(negedge clk);
    push(1, mk(1'b1, 1'b0, 1'b0, 8'h30, 4'h0, 32'h0));
    exp_acc.push_back(1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m1_read && !m1_waitrequest) && k < 50);
    if (k >= 50) begin
      cmp_cnt++; err_cnt++;
      $display("FAIL t5_accept: m1 read never accepted in %0d cycles", k);
    end
    push(0, mk(1'b1, 1'b0, 1'b0, 8'h20, 4'h0, 32'h0));
    exp_acc.push_back(0);
    exp_rd0.push_back(32'hA5000020);
    pulse_reset(2);
    run_phase("t5_reset");

`ifdef SRAM_ARB_STATS_EN
    @(negedge clk); stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(0, mk(1'b1, 1'b0, 1'b0, 8'h20 + 8'(i), 4'h0, 32'h0));
      push(1, mk(1'b1, 1'b0, 1'b0, 8'h30 + 8'(i), 4'h0, 32'h0));
      exp_acc.push_back(1); exp_acc.push_back(0);
      exp_rd0.push_back(32'hA5000020 + 32'(i));
      exp_rd1.push_back(32'hA5000030 + 32'(i));
    end
    run_phase("t6_stats");
    check("stat_conflict", 32'(stat_conflict), 32'd3);
    check("stat_grant0", 32'(stat_grant0), 32'd2);
    check("stat_grant1", 32'(stat_grant1), 32'd2);
    @(negedge clk); stat_clear = 1'b1;
    @(negedge clk); stat_clear = 1'b0;
    check("stat_conflict_clr", 32'(stat_conflict), 32'd0);
    check("stat_grant0_clr", 32'(stat_grant0), 32'd0);
`endif

    check("acc_left", 32'(exp_acc.size()), 32'd0);
    check("rd0_left", 32'(exp_rd0.size()), 32'd0);
    check("rd1_left", 32'(exp_rd1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
